// File: rtl/motion_gen.sv
// Parking-lot sensor stimulus generator: plays one Gray-coded enter/exit pattern on a/b per request.
// Optional one-entry request queue enabled by defining MOTIONGEN_QUEUE_EN.
module motion_gen #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_enter,
  input  logic req_exit,
  output logic a,
  output logic b,
  output logic busy,
  output logic done,
  output logic pending
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_P1   = 2'd1;
  localparam logic [1:0] S_P2   = 2'd2;
  localparam logic [1:0] S_P3   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             launch;
  logic             launch_dir;

  // Sensor pattern for a state; dir=1 plays the enter sequence in reverse order.
  function automatic logic [1:0] phase_ab(input logic [1:0] st, input logic dr);
    logic [1:0] ab;
    case (st)
      S_P1:    ab = dr ? 2'b01 : 2'b10;
      S_P2:    ab = 2'b11;
      S_P3:    ab = dr ? 2'b10 : 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

`ifdef MOTIONGEN_QUEUE_EN
  logic qv_q, qv_d;
  logic qdir_q, qdir_d;
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    launch     = 1'b0;
    launch_dir = 1'b0;
`ifdef MOTIONGEN_QUEUE_EN
    qv_d       = qv_q;
    qdir_d     = qdir_q;
`endif

    if (state_q == S_IDLE) begin
`ifdef MOTIONGEN_QUEUE_EN
      // A queued request launches first; new requests this cycle are not stored.
      if (qv_q) begin
        launch     = 1'b1;
        launch_dir = qdir_q;
        qv_d       = 1'b0;
      end else if (req_enter) begin
        launch     = 1'b1;
        launch_dir = 1'b0;
        if (req_exit) begin
          qv_d   = 1'b1;
          qdir_d = 1'b1;
        end
      end else if (req_exit) begin
        launch     = 1'b1;
        launch_dir = 1'b1;
      end
`else
      if (req_enter) begin
        launch     = 1'b1;
        launch_dir = 1'b0;
      end else if (req_exit) begin
        launch     = 1'b1;
        launch_dir = 1'b1;
      end
`endif
      if (launch) begin
        state_d = S_P1;
        dir_d   = launch_dir;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      if (cnt_q == '0) begin
        case (state_q)
          S_P1:    begin state_d = S_P2;   cnt_d = CNT_LOAD; end
          S_P2:    begin state_d = S_P3;   cnt_d = CNT_LOAD; end
          default: begin state_d = S_IDLE; cnt_d = '0; done_d = 1'b1; end
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
`ifdef MOTIONGEN_QUEUE_EN
      if (!qv_q && (req_enter || req_exit)) begin
        qv_d   = 1'b1;
        qdir_d = !req_enter;
      end
`endif
    end

    {a_d, b_d} = phase_ab(state_d, dir_d);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MOTIONGEN_QUEUE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      qv_q   <= 1'b0;
      qdir_q <= 1'b0;
    end else begin
      qv_q   <= qv_d;
      qdir_q <= qdir_d;
    end
  end

  assign pending = qv_q;
`else
  assign pending = 1'b0;
`endif

  assign a    = a_q;
  assign b    = b_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
